// File: rtl/xyz_sweep_gen_pkg.sv
// Shared encodings for the xyz sweep generator: sweep order modes and FSM states.
`timescale 1ns/1ps
package xyz_sweep_gen_pkg;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_GRAY = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/xyz_code_map.sv
// Combinational sweep-order mapper: turns a sweep index into the xyz vector for the chosen order.
`timescale 1ns/1ps
module xyz_code_map
  import xyz_sweep_gen_pkg::*;
(
  input  logic [2:0] index,
  input  logic [1:0] mode,
  output logic [2:0] vec
);

  // Mode 2'b11 is not a defined order and falls through to a plain binary count.
  always_comb begin
    vec = index;
    case (mode)
      MODE_DOWN: vec = 3'd7 - index;
      MODE_GRAY: vec = index ^ (index >> 1);
      default:   vec = index;
    endcase
  end

endmodule

// File: rtl/xyz_sweep_gen.sv
// Sweeps all eight xyz vectors into the high-even detector, holding each for HOLD_CYCLES clocks,
// and scores the detector's f response against the expected ~z.
`timescale 1ns/1ps
module xyz_sweep_gen
  import xyz_sweep_gen_pkg::*;
#(
  parameter int HOLD_CYCLES = 1,
  parameter int HOLD_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       f_in,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       valid,
  output logic       busy,
  output logic       done,
  output logic [3:0] hit_count,
  output logic       match_err
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  state_t            state;
  state_t            state_next;
  logic [1:0]        mode_q;
  logic [2:0]        index;
  logic [HOLD_W-1:0] hold;
  logic [2:0]        vec_q;
  logic [2:0]        map_index;
  logic [1:0]        map_mode;
  logic [2:0]        map_vec;
  logic              sample;

  assign sample = (state == S_RUN) && (hold == HOLD_LAST);

  // The mapper always looks one vector ahead so x/y/z can come straight from a register;
  // in IDLE it previews vector 0 of the requested mode, captured together with start.
  assign map_index = (state == S_IDLE) ? 3'd0 : index + 3'd1;
  assign map_mode  = (state == S_IDLE) ? mode : mode_q;

  xyz_code_map u_map (
    .index (map_index),
    .mode  (map_mode),
    .vec   (map_vec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (sample && (index == 3'd7)) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // start and mode are only looked at in IDLE, so mid-sweep pulses and mode changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= MODE_UP;
      index     <= 3'd0;
      hold      <= '0;
      vec_q     <= 3'd0;
      hit_count <= 4'd0;
      match_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q    <= mode;
            index     <= 3'd0;
            hold      <= '0;
            vec_q     <= map_vec;
            hit_count <= 4'd0;
            match_err <= 1'b0;
          end
        end
        S_RUN: begin
          if (sample) begin
            hold <= '0;
            if (f_in) hit_count <= hit_count + 4'd1;
            if (f_in == vec_q[0]) match_err <= 1'b1;
            if (index != 3'd7) begin
              index <= index + 3'd1;
              vec_q <= map_vec;
            end
          end else begin
            hold <= hold + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign x     = vec_q[2];
  assign y     = vec_q[1];
  assign z     = vec_q[0];
  assign valid = (state == S_RUN);
  assign busy  = (state == S_RUN) || (state == S_DONE);
  assign done  = (state == S_DONE);

endmodule

// File: tb/tb_xyz_sweep_gen.sv
// Scoreboard bench for xyz_sweep_gen: one instance with HOLD_CYCLES=1 and one with HOLD_CYCLES=3,
// each fed by a behavioural detector that can be switched to faulty responses.
`timescale 1ns/1ps
module tb_xyz_sweep_gen;

  logic       clk;
  logic       rst_n;
  logic       start1, start3;
  logic [1:0] mode1, mode3;
  logic [1:0] fctl;
  logic       f1, f3;
  logic       x1, y1, z1, valid1, busy1, done1, err1;
  logic       x3, y3, z3, valid3, busy3, done3, err3;
  logic [3:0] hit1, hit3;

  int check_count = 0;
  int error_count = 0;
  bit cur = 0;

  logic [2:0] exp_q1[$];
  logic [2:0] exp_q3[$];

  // fctl: 0 = correct detector (~z), 1 = faulty detector (z), 2 = stuck high
  assign f1 = (fctl == 2'd0) ? ~z1 : (fctl == 2'd1) ? z1 : 1'b1;
  assign f3 = (fctl == 2'd0) ? ~z3 : (fctl == 2'd1) ? z3 : 1'b1;

  xyz_sweep_gen #(.HOLD_CYCLES(1), .HOLD_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode1), .f_in(f1),
    .x(x1), .y(y1), .z(z1), .valid(valid1), .busy(busy1), .done(done1),
    .hit_count(hit1), .match_err(err1)
  );

  xyz_sweep_gen #(.HOLD_CYCLES(3), .HOLD_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .mode(mode3), .f_in(f3),
    .x(x3), .y(y3), .z(z3), .valid(valid3), .busy(busy3), .done(done3),
    .hit_count(hit3), .match_err(err3)
  );

  logic [2:0] cur_vec;
  logic       cur_valid, cur_busy, cur_done, cur_err;
  logic [3:0] cur_hit;
  assign cur_vec   = cur ? {x3, y3, z3} : {x1, y1, z1};
  assign cur_valid = cur ? valid3 : valid1;
  assign cur_busy  = cur ? busy3 : busy1;
  assign cur_done  = cur ? done3 : done1;
  assign cur_err   = cur ? err3 : err1;
  assign cur_hit   = cur ? hit3 : hit1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit sel, input logic s, input logic [1:0] m);
    if (sel) begin
      start3 = s;
      mode3  = m;
    end else begin
      start1 = s;
      mode1  = m;
    end
  endtask

  // Independent reference for the sweep order; the Gray order is spelled out as a table.
  function automatic logic [2:0] ref_map(input logic [2:0] i, input logic [1:0] m);
    case (m)
      2'b01: return 3'd7 - i;
      2'b10: begin
        case (i)
          3'd0: return 3'd0;
          3'd1: return 3'd1;
          3'd2: return 3'd3;
          3'd3: return 3'd2;
          3'd4: return 3'd6;
          3'd5: return 3'd7;
          3'd6: return 3'd5;
          default: return 3'd4;
        endcase
      end
      default: return i;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n && valid1) begin
      if (exp_q1.size() == 0) checkOutput("vec1_extra", 32'(valid1), 0);
      else checkOutput("vec1", 32'({x1, y1, z1}), 32'(exp_q1.pop_front()));
    end
    if (rst_n && valid3) begin
      if (exp_q3.size() == 0) checkOutput("vec3_extra", 32'(valid3), 0);
      else checkOutput("vec3", 32'({x3, y3, z3}), 32'(exp_q3.pop_front()));
    end
  end

  task automatic push_expected(input bit sel, input logic [1:0] m, input int hold, input logic [1:0] fc,
                               output int hits, output bit err, output bit err_first);
    logic [2:0] v;
    logic       f;
    hits = 0;
    err = 0;
    err_first = 0;
    for (int i = 0; i < 8; i++) begin
      v = ref_map(3'(i), m);
      f = (fc == 2'd0) ? ~v[0] : (fc == 2'd1) ? v[0] : 1'b1;
      if (f) hits++;
      if (f != ~v[0]) err = 1;
      if (i == 0) err_first = err;
      for (int h = 0; h < hold; h++) begin
        if (sel) exp_q3.push_back(v);
        else     exp_q1.push_back(v);
      end
    end
  endtask

  task automatic run_sweep(input bit sel, input logic [1:0] m, input int hold, input logic [1:0] fc,
                           input bit disturb);
    int hits;
    bit err, err_first;
    int n;
    logic [1:0] other;
    other = m ^ 2'b11;
    cur = sel;
    fctl = fc;
    push_expected(sel, m, hold, fc, hits, err, err_first);
    applyStimulus(sel, 1'b1, m);
    @(negedge clk);
    applyStimulus(sel, 1'b0, m);
    checkOutput("start_hits_clr", 32'(cur_hit), 0);
    checkOutput("start_err_clr", 32'(cur_err), 0);
    checkOutput("start_busy", 32'(cur_busy), 1);
    n = 0;
    while (!cur_done && n < 8 * hold + 20) begin
      if (disturb && n == 3) applyStimulus(sel, 1'b1, other);
      else if (disturb && n == 4) applyStimulus(sel, 1'b0, other);
      @(negedge clk);
      n++;
      if (n == hold) checkOutput("first_sample_err", 32'(cur_err), 32'(err_first));
    end
    checkOutput("done_latency", 32'(n + 1), 32'(8 * hold + 1));
    checkOutput("hits", 32'(cur_hit), 32'(hits));
    checkOutput("match_err", 32'(cur_err), 32'(err));
    checkOutput("valid_in_done", 32'(cur_valid), 0);
    checkOutput("busy_in_done", 32'(cur_busy), 1);
    @(negedge clk);
    checkOutput("done_one_cycle", 32'(cur_done), 0);
    checkOutput("idle_busy", 32'(cur_busy), 0);
    checkOutput("last_vec_held", 32'(cur_vec), 32'(ref_map(3'd7, m)));
    checkOutput("queue_empty", 32'(sel ? exp_q3.size() : exp_q1.size()), 0);
    if (disturb) begin
      repeat (4) begin
        @(negedge clk);
        checkOutput("no_restart", 32'({cur_valid, cur_done}), 0);
      end
      applyStimulus(sel, 1'b0, m);
    end
  endtask

  task automatic reset_mid_sweep();
    int hits;
    bit err, err_first;
    cur = 0;
    fctl = 2'd0;
    push_expected(1'b0, 2'b00, 1, 2'd0, hits, err, err_first);
    applyStimulus(1'b0, 1'b1, 2'b00);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 2'b00);
    repeat (4) @(negedge clk);
    checkOutput("pre_reset_vec", 32'({x1, y1, z1}), 4);
    checkOutput("pre_reset_hits", 32'(hit1), 2);
    rst_n = 1'b0;
    #1;
    checkOutput("reset_abort", 32'({x1, y1, z1, valid1, busy1, done1, hit1, err1}), 0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("reset_no_done", 32'(done1), 0);
    end
    exp_q1.delete();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    fctl = 2'd0;
    applyStimulus(1'b0, 1'b0, 2'b00);
    applyStimulus(1'b1, 1'b0, 2'b00);
    #1;
    checkOutput("reset1", 32'({x1, y1, z1, valid1, busy1, done1, hit1, err1}), 0);
    checkOutput("reset3", 32'({x3, y3, z3, valid3, busy3, done3, hit3, err3}), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] binary up, hold 1");
    run_sweep(1'b0, 2'b00, 1, 2'd0, 1'b0);
    $display("[TB] Gray order, hold 1");
    run_sweep(1'b0, 2'b10, 1, 2'd0, 1'b0);
    $display("[TB] binary down, hold 3");
    run_sweep(1'b1, 2'b01, 3, 2'd0, 1'b0);
    $display("[TB] faulty detector, then clean rerun");
    run_sweep(1'b0, 2'b00, 1, 2'd1, 1'b0);
    run_sweep(1'b0, 2'b00, 1, 2'd0, 1'b0);
    $display("[TB] start and mode disturbed mid-sweep");
    run_sweep(1'b0, 2'b10, 1, 2'd0, 1'b1);
    $display("[TB] stuck-high detector, Gray, hold 3");
    run_sweep(1'b1, 2'b10, 3, 2'd2, 1'b0);
    $display("[TB] reset mid-sweep, then clean sweep");
    reset_mid_sweep();
    run_sweep(1'b0, 2'b00, 1, 2'd0, 1'b0);
    $display("[TB] mode 11 behaves as up");
    run_sweep(1'b0, 2'b11, 1, 2'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
